// File: rtl/reversalmb_requester_if.sv
// ---------------------------------------------------------------------------
// reversalmb_requester_if
// Sideband / pattern-generator handshake bundle for the MBINIT.REVERSALMB
// requester.
//   master : the requester (drives o_*, samples i_*)
//   slave  : the environment (sideband TX/RX, pattern generator, stage chain)
// Signals:
//   i_MBINIT_REPAIRVAL_end   stage enable (level)
//   i_RX_SbMessage/i_msg_valid/i_rx_msg_data  received sideband message
//   i_Busy_SideBand/i_falling_edge_busy        sideband TX status
//   i_pattern_done           pattern generator finished (pulse)
//   o_TX_SbMessage/o_tx_data_valid_reversal    sideband TX request
//   o_pattern_en, o_clear_error, o_lane_reversal
//   o_MBINIT_REVERSALMB_end, o_reversal_error  stage result (levels)
// ---------------------------------------------------------------------------
interface reversalmb_requester_if #(
    parameter int NUM_LANES = 16
);
    logic                 i_MBINIT_REPAIRVAL_end;
    logic [3:0]           i_RX_SbMessage;
    logic                 i_msg_valid;
    logic [NUM_LANES-1:0] i_rx_msg_data;
    logic                 i_Busy_SideBand;
    logic                 i_falling_edge_busy;
    logic                 i_pattern_done;
    logic [3:0]           o_TX_SbMessage;
    logic                 o_tx_data_valid_reversal;
    logic                 o_pattern_en;
    logic                 o_clear_error;
    logic                 o_lane_reversal;
    logic                 o_MBINIT_REVERSALMB_end;
    logic                 o_reversal_error;

    modport master (
        input  i_MBINIT_REPAIRVAL_end, i_RX_SbMessage, i_msg_valid, i_rx_msg_data,
               i_Busy_SideBand, i_falling_edge_busy, i_pattern_done,
        output o_TX_SbMessage, o_tx_data_valid_reversal, o_pattern_en, o_clear_error,
               o_lane_reversal, o_MBINIT_REVERSALMB_end, o_reversal_error
    );

    modport slave (
        output i_MBINIT_REPAIRVAL_end, i_RX_SbMessage, i_msg_valid, i_rx_msg_data,
               i_Busy_SideBand, i_falling_edge_busy, i_pattern_done,
        input  o_TX_SbMessage, o_tx_data_valid_reversal, o_pattern_en, o_clear_error,
               o_lane_reversal, o_MBINIT_REVERSALMB_end, o_reversal_error
    );
endinterface

// File: rtl/reversalmb_requester.sv
// ---------------------------------------------------------------------------
// reversalmb_requester
// MBINIT.REVERSALMB requester stage. Runs init -> clear-error -> per-lane ID
// pattern -> result -> done over the sideband, and decides from the partner's
// per-lane pass vector whether lane reversal is needed (one retry with
// reversal applied). Its o_MBINIT_REVERSALMB_end enables REPAIRMB.
// Ports:
//   CLK   sole clock
//   rst   asynchronous, active-high reset
//   bus   reversalmb_requester_if.master (see interface file)
// Parameters: NUM_LANES, MAJORITY (min passing lanes), TIMEOUT_CYCLES.
// Optional feature: define REVERSALMB_TIMEOUT_EN to add a per-wait timeout
// counter (WAIT_* and PATTERN go to ERROR after TIMEOUT_CYCLES cycles).
// All outputs are registered, decoded from the next state.
// ---------------------------------------------------------------------------
module reversalmb_requester #(
    parameter int NUM_LANES      = 16,
    parameter int MAJORITY       = 9,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                    CLK,
    input  logic                    rst,
    reversalmb_requester_if.master  bus
);
    localparam int PC_W = $clog2(NUM_LANES + 1);

    localparam logic [3:0] MSG_INIT_REQ  = 4'd1;
    localparam logic [3:0] MSG_INIT_RESP = 4'd2;
    localparam logic [3:0] MSG_CLR_REQ   = 4'd3;
    localparam logic [3:0] MSG_CLR_RESP  = 4'd4;
    localparam logic [3:0] MSG_RES_REQ   = 4'd5;
    localparam logic [3:0] MSG_RES_RESP  = 4'd6;
    localparam logic [3:0] MSG_DONE_REQ  = 4'd7;
    localparam logic [3:0] MSG_DONE_RESP = 4'd8;

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] SEND_INIT   = 4'd1;
    localparam logic [3:0] WAIT_INIT   = 4'd2;
    localparam logic [3:0] RDY_CLR     = 4'd3;
    localparam logic [3:0] SEND_CLR    = 4'd4;
    localparam logic [3:0] WAIT_CLR    = 4'd5;
    localparam logic [3:0] PATTERN     = 4'd6;
    localparam logic [3:0] RDY_RES     = 4'd7;
    localparam logic [3:0] SEND_RESULT = 4'd8;
    localparam logic [3:0] WAIT_RESULT = 4'd9;
    localparam logic [3:0] RDY_DONE    = 4'd10;
    localparam logic [3:0] SEND_DONE   = 4'd11;
    localparam logic [3:0] WAIT_DONE   = 4'd12;
    localparam logic [3:0] DONE        = 4'd13;
    localparam logic [3:0] ERROR       = 4'd14;

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic            r_tried;
    logic            r_lane_rev;
    logic [3:0]      r_tx_msg;
    logic [3:0]      w_tx_msg;
    logic            r_tx_valid;
    logic            r_pattern_en;
    logic            r_clear_error;
    logic            r_end;
    logic            r_err;
    logic [3:0]      w_rx_code;
    logic [PC_W-1:0] w_popcnt;
    logic            w_pass;
    logic            w_en;

    assign w_en = bus.i_MBINIT_REPAIRVAL_end;

    // Code 0 is never a valid message, so folding valid into the code lets
    // every WAIT state compare against a single signal.
    assign w_rx_code = bus.i_msg_valid ? bus.i_RX_SbMessage : 4'd0;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w_popcnt = w_popcnt + PC_W'(bus.i_rx_msg_data[i]);
    end

    assign w_pass = (w_popcnt >= PC_W'(MAJORITY));

`ifdef REVERSALMB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        w_in_wait;

    assign w_in_wait = (r_state == WAIT_INIT) || (r_state == WAIT_CLR) ||
                       (r_state == PATTERN)   || (r_state == WAIT_RESULT) ||
                       (r_state == WAIT_DONE);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (!bus.i_Busy_SideBand)            w_next = SEND_INIT;
            SEND_INIT:   if (bus.i_falling_edge_busy)         w_next = WAIT_INIT;
            WAIT_INIT:   if (w_rx_code == MSG_INIT_RESP)      w_next = RDY_CLR;
            RDY_CLR:     if (!bus.i_Busy_SideBand)            w_next = SEND_CLR;
            SEND_CLR:    if (bus.i_falling_edge_busy)         w_next = WAIT_CLR;
            WAIT_CLR:    if (w_rx_code == MSG_CLR_RESP)       w_next = PATTERN;
            PATTERN:     if (bus.i_pattern_done)              w_next = RDY_RES;
            RDY_RES:     if (!bus.i_Busy_SideBand)            w_next = SEND_RESULT;
            SEND_RESULT: if (bus.i_falling_edge_busy)         w_next = WAIT_RESULT;
            WAIT_RESULT: if (w_rx_code == MSG_RES_RESP) begin
                             if (w_pass)       w_next = RDY_DONE;
                             else if (r_tried) w_next = ERROR;
                             else              w_next = RDY_CLR;
                         end
            RDY_DONE:    if (!bus.i_Busy_SideBand)            w_next = SEND_DONE;
            SEND_DONE:   if (bus.i_falling_edge_busy)         w_next = WAIT_DONE;
            WAIT_DONE:   if (w_rx_code == MSG_DONE_RESP)      w_next = DONE;
            DONE:        w_next = DONE;
            ERROR:       w_next = ERROR;
            default:     w_next = IDLE;
        endcase
`ifdef REVERSALMB_TIMEOUT_EN
        // A message arriving on the last allowed cycle still wins.
        if (w_in_wait && (w_next == r_state) && (r_cnt == 16'(TIMEOUT_CYCLES - 1)))
            w_next = ERROR;
`endif
        // Enable loss overrides everything, including a coincident message.
        if (!w_en)
            w_next = IDLE;
    end

    always_comb begin
        case (w_next)
            SEND_INIT:   w_tx_msg = MSG_INIT_REQ;
            SEND_CLR:    w_tx_msg = MSG_CLR_REQ;
            SEND_RESULT: w_tx_msg = MSG_RES_REQ;
            SEND_DONE:   w_tx_msg = MSG_DONE_REQ;
            default:     w_tx_msg = 4'd0;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_tried       <= 1'b0;
            r_lane_rev    <= 1'b0;
            r_tx_msg      <= 4'd0;
            r_tx_valid    <= 1'b0;
            r_pattern_en  <= 1'b0;
            r_clear_error <= 1'b0;
            r_end         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_tx_msg      <= w_tx_msg;
            r_tx_valid    <= (w_tx_msg != 4'd0);
            r_pattern_en  <= (w_next == PATTERN);
            r_clear_error <= (r_state == WAIT_CLR) && (w_next == PATTERN);
            r_end         <= (w_next == DONE);
            r_err         <= (w_next == ERROR);
            if (!w_en) begin
                r_lane_rev <= 1'b0;
                r_tried    <= 1'b0;
            end else if ((r_state == WAIT_RESULT) && (w_next == RDY_CLR)) begin
                // First failing result: retry once with lanes reversed.
                r_lane_rev <= 1'b1;
                r_tried    <= 1'b1;
            end
        end
    end

`ifdef REVERSALMB_TIMEOUT_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            r_cnt <= 16'd0;
        else if (w_next != r_state)
            r_cnt <= 16'd0;
        else if (w_in_wait)
            r_cnt <= r_cnt + 16'd1;
    end
`endif

    assign bus.o_TX_SbMessage           = r_tx_msg;
    assign bus.o_tx_data_valid_reversal = r_tx_valid;
    assign bus.o_pattern_en             = r_pattern_en;
    assign bus.o_clear_error            = r_clear_error;
    assign bus.o_lane_reversal          = r_lane_rev;
    assign bus.o_MBINIT_REVERSALMB_end  = r_end;
    assign bus.o_reversal_error         = r_err;

endmodule

// File: tb/tb_reversalmb_requester.sv
// ---------------------------------------------------------------------------
// tb_reversalmb_requester
// Directed bench for reversalmb_requester. Inputs change on the falling edge;
// outputs are sampled on the falling edge (half a cycle after the active
// edge). Sideband partner behaviour is emulated by small tasks.
// ---------------------------------------------------------------------------
module tb_reversalmb_requester;
    localparam logic [3:0] INIT_REQ = 4'd1, INIT_RESP = 4'd2;
    localparam logic [3:0] CLR_REQ  = 4'd3, CLR_RESP  = 4'd4;
    localparam logic [3:0] RES_REQ  = 4'd5, RES_RESP  = 4'd6;
    localparam logic [3:0] DONE_REQ = 4'd7, DONE_RESP = 4'd8;

    logic CLK;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_clr_sent = 0;
    int   n_done_sent = 0;
    logic r_prev_v = 1'b0;

    reversalmb_requester_if #(.NUM_LANES(16)) b ();

    reversalmb_requester #(
        .NUM_LANES(16), .MAJORITY(9), .TIMEOUT_CYCLES(20)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counts requests actually launched by the DUT (rising edge of TX valid).
    always @(posedge CLK) begin
        r_prev_v <= b.o_tx_data_valid_reversal;
        if (b.o_tx_data_valid_reversal && !r_prev_v) begin
            if (b.o_TX_SbMessage == CLR_REQ)  n_clr_sent  <= n_clr_sent + 1;
            if (b.o_TX_SbMessage == DONE_REQ) n_done_sent <= n_done_sent + 1;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {msg[3:0], valid, pattern_en, clear_error, lane_rev, end, error}
    function automatic logic [31:0] outs();
        return {22'd0, b.o_TX_SbMessage, b.o_tx_data_valid_reversal, b.o_pattern_en,
                b.o_clear_error, b.o_lane_reversal, b.o_MBINIT_REVERSALMB_end,
                b.o_reversal_error};
    endfunction

    // Wait (bounded) for a request, check it, then emulate the sideband send.
    task automatic wait_req(input logic [3:0] code, input string tag);
        int n = 0;
        while (!(b.o_tx_data_valid_reversal && b.o_TX_SbMessage == code) && n < 100) begin
            tick();
            n++;
        end
        check(tag, {27'd0, b.o_tx_data_valid_reversal, b.o_TX_SbMessage}, {27'd0, 1'b1, code});
        b.i_Busy_SideBand = 1'b1;
        tick();
        tick();
        b.i_Busy_SideBand     = 1'b0;
        b.i_falling_edge_busy = 1'b1;
        tick();
        b.i_falling_edge_busy = 1'b0;
    endtask

    task automatic send_resp(input logic [3:0] code, input logic [15:0] data);
        b.i_msg_valid    = 1'b1;
        b.i_RX_SbMessage = code;
        b.i_rx_msg_data  = data;
        tick();
        b.i_msg_valid    = 1'b0;
        b.i_RX_SbMessage = 4'd0;
        b.i_rx_msg_data  = 16'd0;
    endtask

    task automatic start();
        b.i_MBINIT_REPAIRVAL_end = 1'b1;
        wait_req(INIT_REQ, "init_req");
        send_resp(INIT_RESP, 16'd0);
    endtask

    // One clear -> pattern -> result round; leaves the bench just after result_resp.
    task automatic attempt(input logic [15:0] res);
        wait_req(CLR_REQ, "clr_req");
        send_resp(CLR_RESP, 16'd0);
        check("clr_pulse_pat_en", {30'd0, b.o_clear_error, b.o_pattern_en}, 32'd3);
        tick();
        check("clr_pulse_gone", {30'd0, b.o_clear_error, b.o_pattern_en}, 32'd1);
        b.i_pattern_done = 1'b1;
        tick();
        b.i_pattern_done = 1'b0;
        check("pat_en_drop", {31'd0, b.o_pattern_en}, 32'd0);
        wait_req(RES_REQ, "result_req");
        send_resp(RES_RESP, res);
    endtask

    task automatic finish_done(input string tag);
        wait_req(DONE_REQ, "done_req");
        send_resp(DONE_RESP, 16'd0);
        check(tag, {29'd0, b.o_MBINIT_REVERSALMB_end, b.o_reversal_error, 1'b0},
              {29'd0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic disable_stage(input string tag);
        b.i_MBINIT_REPAIRVAL_end = 1'b0;
        tick();
        check(tag, outs(), 32'd0);
    endtask

    initial begin
        int clr0;
        int done0;
        rst = 1'b1;
        b.i_MBINIT_REPAIRVAL_end = 1'b0;
        b.i_RX_SbMessage = 4'd0;
        b.i_msg_valid = 1'b0;
        b.i_rx_msg_data = 16'd0;
        b.i_Busy_SideBand = 1'b0;
        b.i_falling_edge_busy = 1'b0;
        b.i_pattern_done = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), 32'd0);

        // Clean pass, with ignored wrong/invalid messages in WAIT_INIT.
        clr0 = n_clr_sent;
        b.i_MBINIT_REPAIRVAL_end = 1'b1;
        wait_req(INIT_REQ, "init_req");
        send_resp(DONE_RESP, 16'd0);
        b.i_RX_SbMessage = INIT_RESP;
        tick();
        b.i_RX_SbMessage = 4'd0;
        tick();
        check("wrong_msg_ignored", {31'd0, b.o_tx_data_valid_reversal}, 32'd0);
        send_resp(INIT_RESP, 16'd0);
        attempt(16'hFFFF);
        check("pass_no_rev", {31'd0, b.o_lane_reversal}, 32'd0);
        finish_done("pass_end");
        tick();
        check("pass_end_held", outs(), 32'h2);
        check("pass_clr_count", n_clr_sent - clr0, 32'd1);
        disable_stage("pass_disable");

        // Reversal retry: first all-fail, then all-pass.
        clr0 = n_clr_sent;
        start();
        attempt(16'h0000);
        check("rev_applied", {30'd0, b.o_lane_reversal, b.o_reversal_error}, 32'd2);
        attempt(16'hFFFF);
        finish_done("rev_end");
        check("rev_kept", {31'd0, b.o_lane_reversal}, 32'd1);
        check("rev_clr_count", n_clr_sent - clr0, 32'd2);
        disable_stage("rev_disable");

        // Double fail: 8 lanes, then 1 lane.
        done0 = n_done_sent;
        start();
        attempt(16'h00FF);
        check("dbl_first_rev", {31'd0, b.o_lane_reversal}, 32'd1);
        attempt(16'h0100);
        check("dbl_error", {30'd0, b.o_MBINIT_REVERSALMB_end, b.o_reversal_error}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("dbl_error_held", outs(), 32'h5);
        check("dbl_no_done_req", n_done_sent - done0, 32'd0);
        disable_stage("dbl_disable");

        // Threshold: exactly MAJORITY passing lanes succeeds first time.
        start();
        attempt(16'h01FF);
        check("thr9_no_rev", {30'd0, b.o_lane_reversal, b.o_reversal_error}, 32'd0);
        finish_done("thr9_end");
        disable_stage("thr9_disable");

        // Abort in WAIT_CLR of the retry with a coincident clear_error_resp.
        start();
        attempt(16'h0000);
        wait_req(CLR_REQ, "abort_clr_req");
        b.i_MBINIT_REPAIRVAL_end = 1'b0;
        send_resp(CLR_RESP, 16'd0);
        check("abort_outs", outs(), 32'd0);
        tick();
        check("abort_idle", outs(), 32'd0);
        // tried must be cleared: a single failure retries again, no error.
        start();
        attempt(16'h0000);
        check("abort_tried_clear", {30'd0, b.o_lane_reversal, b.o_reversal_error}, 32'd2);
        disable_stage("abort_disable");

        // Asynchronous reset mid-operation (in PATTERN).
        start();
        wait_req(CLR_REQ, "rst_clr_req");
        send_resp(CLR_RESP, 16'd0);
        rst = 1'b1;
        #1;
        check("async_rst", outs(), 32'd0);
        b.i_MBINIT_REPAIRVAL_end = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", outs(), 32'd0);

        // Timeout behaviour in WAIT_INIT.
        b.i_MBINIT_REPAIRVAL_end = 1'b1;
        wait_req(INIT_REQ, "to_init_req");
`ifdef REVERSALMB_TIMEOUT_EN
        for (int i = 0; i < 19; i++) tick();
        check("to_not_yet", {31'd0, b.o_reversal_error}, 32'd0);
        tick();
        check("to_error", {31'd0, b.o_reversal_error}, 32'd1);
`else
        for (int i = 0; i < 1000; i++) tick();
        check("no_to_waiting", outs(), 32'd0);
        send_resp(INIT_RESP, 16'd0);
        wait_req(CLR_REQ, "no_to_resume");
`endif
        disable_stage("to_disable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
